dmem_responder: RTL and testbench

Multi-cycle data-memory responder that sits at the far end of the memory-stage load/store interface of the pipelined RV32 core. It accepts one word request at a time and models LATENCY wait states. It returns read data with a one-cycle response strobe. While a request is outstanding it drives a stall so the hazard logic holds the pipeline.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, counter width
// and access-check result codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  // Alignment is checked before range so a misaligned far address reports ALIGN.
  function automatic logic [1:0] addr_check(input logic [31:0] addr, input int addr_w);
    if (addr[1:0] != 2'b00) return ERR_ALIGN;
    if ((addr >> (addr_w + 2)) != 32'd0) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous write, asynchronous read. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] ridx,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word request, waits LATENCY
// cycles, performs the access and returns a one-cycle response strobe.
//
// state | meaning
// IDLE  | ready for a request; latches it when req_valid is high
// WAIT  | counting down wait states; access happens on the cnt==0 edge
// RESP  | rsp_valid high for one cycle; never accepts
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  localparam int ADDR_W     = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic [1:0]         err_code;
  logic [ADDR_W-1:0]  idx;
  logic               access;
  logic               wr_en;
  logic [31:0]        arr_rdata;

  assign err_code = addr_check(addr_q, ADDR_W);
  assign idx      = addr_q[ADDR_W+1:2];
  assign access   = (state == WAIT) && (cnt == '0);
  // Gating with rst drops a store whose commit edge coincides with reset.
  assign wr_en    = rst && access && we_q && (err_code == ERR_NONE);
  assign stall    = req_valid & ~rsp_valid;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (wr_en),
    .widx (idx),
    .wdata(wdata_q),
    .ridx (idx),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
            if (err_code != ERR_NONE) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              rsp_rdata <= we_q ? 32'd0 : arr_rdata;
              rsp_err   <= 1'b0;
            end
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (LATENCY=2 and LATENCY=1) driven by
// directed and random requests, checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        rv        [2];
  logic        rwe       [2];
  logic [31:0] ra        [2];
  logic [31:0] rwd       [2];
  logic        ready     [2];
  logic        rsp_valid [2];
  logic [31:0] rdata     [2];
  logic        rsp_err   [2];
  logic        stall     [2];

  int          tests  = 0;
  int          failed = 0;
  int          lat_of [2] = '{2, 1};

  logic [31:0] mem_m   [2][DEPTH];
  bit          wr_m    [2][DEPTH];
  bit          last_ok [2];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata[0]), .rsp_err(rsp_err[0]),
    .stall(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata[1]), .rsp_err(rsp_err[1]),
    .stall(stall[1])
  );

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT in IDLE; returns at the negedge
  // inside the response cycle.
  task automatic xact(input int i, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input bit hold_after);
    int          k;
    bit          bad;
    int          idx;
    logic [31:0] exp_rd;
    bit          check_rd;
    rv[i] = 1'b1; rwe[i] = we; ra[i] = addr; rwd[i] = wd;
    #1;
    chk("ready_c0", i, 32'(ready[i]), 32'd1);
    chk("stall_c0", i, 32'(stall[i]), 32'd1);
    if (last_ok[i]) chk("rdata_hold", i, rdata[i], last_rd[i]);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (rsp_valid[i]) break;
      chk("stall_wait", i, 32'(stall[i]), 32'd1);
      if (k == 1) begin
        ra[i] = $urandom; rwd[i] = $urandom; rwe[i] = 1'($urandom);
      end
    end
    chk("latency", i, 32'(k), 32'(lat_of[i] + 1));
    bad = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    idx = int'(addr >> 2) % DEPTH;
    chk("err", i, 32'(rsp_err[i]), 32'(bad));
    check_rd = 1'b1;
    exp_rd   = 32'd0;
    if (!bad && !we) begin
      if (wr_m[i][idx]) exp_rd = mem_m[i][idx];
      else check_rd = 1'b0;
    end
    if (check_rd) chk("rdata", i, rdata[i], exp_rd);
    last_ok[i] = check_rd;
    last_rd[i] = exp_rd;
    chk("stall_resp", i, 32'(stall[i]), 32'd0);
    if (!bad && we) begin
      mem_m[i][idx] = wd;
      wr_m[i][idx]  = 1'b1;
    end
    if (!hold_after) rv[i] = 1'b0;
  endtask

  task automatic quiet(input int i, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("no_rsp", i, 32'(rsp_valid[i]), 32'd0);
      chk("idle_ready", i, 32'(ready[i]), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; rv[i] = 1'b0; rwe[i] = 1'b0; ra[i] = '0; rwd[i] = '0;
      last_ok[i] = 1'b0; last_rd[i] = '0;
      for (int w = 0; w < DEPTH; w++) wr_m[i][w] = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      // Reset held with a request present.
      @(negedge clk);
      rst[i] = 1'b0; rv[i] = 1'b1; rwe[i] = 1'b1; ra[i] = 32'h40; rwd[i] = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
        chk("rst_stall", i, 32'(stall[i]), 32'd1);
      end
      rst[i] = 1'b1; rv[i] = 1'b0;
      #1;
      chk("rst_ready", i, 32'(ready[i]), 32'd1);
      chk("rst_rdata", i, rdata[i], 32'd0);
      chk("rst_err", i, 32'(rsp_err[i]), 32'd0);
      quiet(i, 3);
      last_ok[i] = 1'b1; last_rd[i] = '0;

      xact(i, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0); @(negedge clk);
      xact(i, 1'b0, 32'h10, 32'h0, 1'b0);         @(negedge clk);
      xact(i, 1'b0, 32'h13, 32'h0, 1'b0);         @(negedge clk);
      xact(i, 1'b1, 32'h0, 32'hCAFE_F00D, 1'b0);  @(negedge clk);
      xact(i, 1'b1, 32'h1000, 32'h0000_0BAD, 1'b0); @(negedge clk);
      xact(i, 1'b0, 32'h0, 32'h0, 1'b0);          @(negedge clk);

      // Back-to-back: the store stays asserted through RESP, load follows.
      xact(i, 1'b1, 32'h20, 32'h1, 1'b1);         @(negedge clk);
      xact(i, 1'b0, 32'h20, 32'h0, 1'b0);
      quiet(i, 3);

      // Reset in the first WAIT cycle drops the pending store.
      xact(i, 1'b1, 32'h30, 32'h1111_1111, 1'b0); @(negedge clk);
      rv[i] = 1'b1; rwe[i] = 1'b1; ra[i] = 32'h30; rwd[i] = 32'hA5A5_A5A5;
      @(negedge clk);
      rst[i] = 1'b0;
      @(negedge clk);
      rst[i] = 1'b1; rv[i] = 1'b0;
      chk("midrst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      quiet(i, 4);
      last_ok[i] = 1'b1; last_rd[i] = '0;
      xact(i, 1'b0, 32'h30, 32'h0, 1'b0);         @(negedge clk);

      // Prefill a small window, then random mixed traffic over it.
      for (int w = 0; w < 16; w++) begin
        xact(i, 1'b1, 32'(w * 4), $urandom, 1'b0); @(negedge clk);
      end
      for (int n = 0; n < 40; n++) begin
        int          r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
        else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
        else             a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        xact(i, 1'($urandom), a, $urandom, 1'($urandom));
        @(negedge clk);
      end
      rv[i] = 1'b0;
      quiet(i, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
